// File: rtl/core_pkg.sv
// Shared types and constants for the core's memory-side blocks.
// The read arbiter uses the state encoding and requester port indices below.
package core_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GNT_IF = 2'd1,
    GNT_LS = 2'd2
  } arb_state_e;

  localparam logic ARB_PORT_IF = 1'b0;
  localparam logic ARB_PORT_LS = 1'b1;

endpackage

// File: rtl/read_arb_pick.sv
// Combinational winner select between the fetch and load/store requesters.
// Define READ_ARB_RR_EN for round-robin on ties; otherwise LS has fixed priority.
module read_arb_pick
  import core_pkg::*;
(
  input  logic req_ls,
  input  logic req_if,
  input  logic last_grant,
  output logic gnt_valid,
  output logic gnt_port
);

  assign gnt_valid = req_ls | req_if;

`ifdef READ_ARB_RR_EN
  // On a tie the port that was not granted last time goes first.
  always_comb begin
    gnt_port = ARB_PORT_LS;
    if (req_ls && req_if) begin
      gnt_port = ~last_grant;
    end else if (req_if) begin
      gnt_port = ARB_PORT_IF;
    end
  end
`else
  logic unused_last_grant;
  assign unused_last_grant = last_grant;

  always_comb begin
    gnt_port = req_ls ? ARB_PORT_LS : ARB_PORT_IF;
  end
`endif

endmodule

// File: rtl/read_arbiter.sv
// Two-port read arbiter: fetch and load/store share one RAM read port, one read in flight.
// Define READ_ARB_RR_EN to build the round-robin variant with a last-grant register.
module read_arbiter
  import core_pkg::*;
#(
  parameter int ADDR_WIDTH = 31,
  parameter int DATA_WIDTH = 31
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clk_en,
  input  logic                  i_if_req,
  input  logic [ADDR_WIDTH:0]   i_if_addr,
  output logic                  o_if_rvalid,
  output logic [DATA_WIDTH:0]   o_if_rdata,
  input  logic                  i_ls_req,
  input  logic [ADDR_WIDTH:0]   i_ls_addr,
  output logic                  o_ls_rvalid,
  output logic [DATA_WIDTH:0]   o_ls_rdata,
  output logic                  o_read_req,
  output logic [ADDR_WIDTH:0]   o_read_addr,
  input  logic [DATA_WIDTH:0]   i_read_data,
  input  logic                  i_read_ready
);

  arb_state_e          state_q, state_d;
  logic                read_req_q, read_req_d;
  logic [ADDR_WIDTH:0] read_addr_q, read_addr_d;
  logic                last_grant;
  logic                gnt_valid;
  logic                gnt_port;
  logic                complete;

`ifdef READ_ARB_RR_EN
  logic last_grant_q, last_grant_d;
  assign last_grant = last_grant_q;
`else
  assign last_grant = ARB_PORT_IF;
`endif

  read_arb_pick u_pick (
    .req_ls     (i_ls_req),
    .req_if     (i_if_req),
    .last_grant (last_grant),
    .gnt_valid  (gnt_valid),
    .gnt_port   (gnt_port)
  );

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case leaves a latch.
    state_d     = state_q;
    read_req_d  = read_req_q;
    read_addr_d = read_addr_q;
`ifdef READ_ARB_RR_EN
    last_grant_d = last_grant_q;
`endif
    case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          state_d     = (gnt_port == ARB_PORT_LS) ? GNT_LS : GNT_IF;
          read_req_d  = 1'b1;
          read_addr_d = (gnt_port == ARB_PORT_LS) ? i_ls_addr : i_if_addr;
`ifdef READ_ARB_RR_EN
          last_grant_d = gnt_port;
`endif
        end
      end
      GNT_IF, GNT_LS: begin
        if (i_read_ready) begin
          state_d    = IDLE;
          read_req_d = 1'b0;
        end
      end
      default: begin
        state_d    = IDLE;
        read_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state updates use non-blocking assignments; reset wins over clk_en so a stalled core can still be cleared.
    if (rst) begin
      state_q     <= IDLE;
      read_req_q  <= 1'b0;
      read_addr_q <= '0;
`ifdef READ_ARB_RR_EN
      last_grant_q <= ARB_PORT_IF;
`endif
    end else if (clk_en) begin
      state_q     <= state_d;
      read_req_q  <= read_req_d;
      read_addr_q <= read_addr_d;
`ifdef READ_ARB_RR_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  // Zero-cycle response: completion is visible in the same cycle as i_read_ready.
  assign complete    = (state_q != IDLE) & i_read_ready & clk_en & ~rst;
  assign o_if_rvalid = complete & (state_q == GNT_IF);
  assign o_ls_rvalid = complete & (state_q == GNT_LS);
  assign o_if_rdata  = i_read_data;
  assign o_ls_rdata  = i_read_data;
  assign o_read_req  = read_req_q;
  assign o_read_addr = read_addr_q;

endmodule

// File: tb/tb_read_arbiter.sv
// Self-checking bench for read_arbiter: directed scenarios plus a randomized phase,
// all compared against a transaction-level model of the arbitration rules.
module tb_read_arbiter;
  import core_pkg::*;

  localparam int AW = 31;
  localparam int DW = 31;
`ifdef READ_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, clk_en;
  logic          i_if_req, i_ls_req, i_read_ready;
  logic [AW:0]   i_if_addr, i_ls_addr;
  logic [DW:0]   i_read_data;
  logic          o_if_rvalid, o_ls_rvalid, o_read_req;
  logic [DW:0]   o_if_rdata, o_ls_rdata;
  logic [AW:0]   o_read_addr;

  read_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en),
    .i_if_req(i_if_req), .i_if_addr(i_if_addr), .o_if_rvalid(o_if_rvalid), .o_if_rdata(o_if_rdata),
    .i_ls_req(i_ls_req), .i_ls_addr(i_ls_addr), .o_ls_rvalid(o_ls_rvalid), .o_ls_rdata(o_ls_rdata),
    .o_read_req(o_read_req), .o_read_addr(o_read_addr),
    .i_read_data(i_read_data), .i_read_ready(i_read_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Transaction-level reference: at most one read outstanding, owned by one port.
  bit          m_busy;
  logic        m_owner;
  logic [AW:0] m_addr;
  logic        m_last;
  int          m_wait;
  int          m_done;

  // Requesters hold each queued address until it is served; memory answers after mem_lat cycles.
  logic [AW:0] if_q[$];
  logic [AW:0] ls_q[$];
  bit          auto_mem;
  bit          rand_mode;
  int          mem_lat;
  logic [DW:0] mem_data;

  int          if_pulses, ls_pulses;
  logic [DW:0] if_seen, ls_seen;
  int          obs_order[$];
  int          obs_cyc[$];
  logic [AW:0] obs_addr[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_obs();
    if_pulses = 0; ls_pulses = 0;
    if_seen = '0; ls_seen = '0;
    obs_order.delete(); obs_cyc.delete(); obs_addr.delete();
  endtask

  task automatic drive();
    i_if_req  = (if_q.size() > 0);
    i_if_addr = i_if_req ? if_q[0] : '0;
    i_ls_req  = (ls_q.size() > 0);
    i_ls_addr = i_ls_req ? ls_q[0] : '0;
    i_read_data = rand_mode ? DW'($urandom) : mem_data;
    if (auto_mem) begin
      if (m_busy) i_read_ready = (m_wait >= mem_lat);
      else        i_read_ready = rand_mode && ($urandom_range(0, 1) == 1);
    end
  endtask

  task automatic cycle();
    logic fire, exp_if, exp_ls;
    int   w;
    drive();
    @(negedge clk);
    fire   = m_busy && i_read_ready && clk_en && !rst;
    exp_if = fire && (m_owner == ARB_PORT_IF);
    exp_ls = fire && (m_owner == ARB_PORT_LS);
    check("read_req",  64'(o_read_req),  64'(m_busy));
    check("read_addr", 64'(o_read_addr), 64'(m_addr));
    check("if_rvalid", 64'(o_if_rvalid), 64'(exp_if));
    check("ls_rvalid", 64'(o_ls_rvalid), 64'(exp_ls));
    check("if_rdata",  64'(o_if_rdata),  64'(i_read_data));
    check("ls_rdata",  64'(o_ls_rdata),  64'(i_read_data));
    if (o_if_rvalid === 1'b1) begin
      if_pulses++; if_seen = o_if_rdata;
      obs_order.push_back(0); obs_cyc.push_back(cyc); obs_addr.push_back(o_read_addr);
    end
    if (o_ls_rvalid === 1'b1) begin
      ls_pulses++; ls_seen = o_ls_rdata;
      obs_order.push_back(1); obs_cyc.push_back(cyc); obs_addr.push_back(o_read_addr);
    end
    @(posedge clk);
    if (rst) begin
      m_busy = 1'b0; m_addr = '0; m_last = ARB_PORT_IF;
    end else if (clk_en) begin
      if (m_busy) begin
        if (i_read_ready) begin
          m_busy = 1'b0; m_done++;
          if (m_owner == ARB_PORT_LS) void'(ls_q.pop_front());
          else                        void'(if_q.pop_front());
        end else begin
          m_wait++;
        end
      end else if (i_if_req || i_ls_req) begin
        if (i_if_req && i_ls_req) w = RR ? ((m_last == ARB_PORT_LS) ? 0 : 1) : 1;
        else                      w = i_ls_req ? 1 : 0;
        m_busy  = 1'b1;
        m_owner = (w == 1) ? ARB_PORT_LS : ARB_PORT_IF;
        m_addr  = (w == 1) ? i_ls_addr : i_if_addr;
        m_last  = m_owner;
        m_wait  = 0;
      end
    end
    cyc++;
    #1;
  endtask

  task automatic run_drain(input int limit);
    int n = 0;
    while ((if_q.size() > 0 || ls_q.size() > 0 || m_busy) && n < limit) begin
      cycle();
      n++;
    end
    if (n == limit) check("drain_timeout", 64'(n), 64'(0));
    cycle();
  endtask

  initial begin
    int exp_order[8];
    logic [AW:0] a;

    rst = 1'b1; clk_en = 1'b1;
    i_if_req = 1'b0; i_ls_req = 1'b0; i_if_addr = '0; i_ls_addr = '0;
    i_read_ready = 1'b0; i_read_data = '0;
    auto_mem = 1'b1; rand_mode = 1'b0; mem_lat = 0; mem_data = '0;
    m_busy = 1'b0; m_owner = ARB_PORT_IF; m_addr = '0; m_last = ARB_PORT_IF; m_wait = 0; m_done = 0;
    clear_obs();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_read_req",  64'(o_read_req),  64'(0));
    check("reset_read_addr", 64'(o_read_addr), 64'(0));
    check("reset_if_rvalid", 64'(o_if_rvalid), 64'(0));
    check("reset_ls_rvalid", 64'(o_ls_rvalid), 64'(0));

    // IF alone, 3-cycle memory
    clear_obs(); mem_lat = 3; mem_data = 32'hDEADBEEF;
    if_q.push_back(32'h100);
    run_drain(50);
    check("t1_if_pulses", 64'(if_pulses), 64'(1));
    check("t1_ls_pulses", 64'(ls_pulses), 64'(0));
    check("t1_if_data",   64'(if_seen),   64'(32'hDEADBEEF));
    check("t1_addr",      64'(o_read_addr), 64'(32'h100));

    // Simultaneous IF and LS: LS first, then one IDLE cycle, then IF
    clear_obs(); mem_lat = 2; mem_data = 32'h1234_5678;
    if_q.push_back(32'h100); ls_q.push_back(32'h2000);
    run_drain(50);
    check("t2_pulses", 64'(obs_order.size()), 64'(2));
    if (obs_order.size() == 2) begin
      check("t2_first_ls",  64'(obs_order[0]), 64'(1));
      check("t2_second_if", 64'(obs_order[1]), 64'(0));
      check("t2_ls_addr",   64'(obs_addr[0]),  64'(32'h2000));
      check("t2_if_addr",   64'(obs_addr[1]),  64'(32'h100));
      check("t2_spacing",   64'(obs_cyc[1] - obs_cyc[0]), 64'(2 + 2));
    end

    // Both requesters held for four reads each
    clear_obs(); mem_lat = 0;
    for (int i = 0; i < 4; i++) begin
      if_q.push_back(32'h100 + 32'(4 * i));
      ls_q.push_back(32'h2000 + 32'(4 * i));
      exp_order[2 * i]     = RR ? 1 : 1;
      exp_order[2 * i + 1] = RR ? 0 : 1;
    end
    if (!RR) for (int i = 4; i < 8; i++) exp_order[i] = 0;
    run_drain(100);
    check("t3_pulses", 64'(obs_order.size()), 64'(8));
    if (obs_order.size() == 8)
      for (int i = 0; i < 8; i++) check($sformatf("t3_order_%0d", i), 64'(obs_order[i]), 64'(exp_order[i]));

    // Reset during GNT_LS, late ready afterwards
    clear_obs(); mem_lat = 20;
    ls_q.push_back(32'h2000);
    cycle(); cycle();
    check("t4_granted", 64'(o_read_req), 64'(1));
    ls_q.delete();
    rst = 1'b1;
    cycle();
    rst = 1'b0; auto_mem = 1'b0; i_read_ready = 1'b1;
    cycle(); cycle();
    check("t4_read_req", 64'(o_read_req), 64'(0));
    check("t4_no_rvalid", 64'(if_pulses + ls_pulses), 64'(0));
    i_read_ready = 1'b0; auto_mem = 1'b1;

    // clk_en low while the memory answers
    clear_obs(); mem_lat = 1;
    if_q.push_back(32'h300);
    cycle();
    auto_mem = 1'b0; i_read_ready = 1'b1; clk_en = 1'b0;
    repeat (3) cycle();
    check("t5_stalled", 64'(if_pulses), 64'(0));
    check("t5_addr_held", 64'(o_read_addr), 64'(32'h300));
    clk_en = 1'b1;
    cycle();
    check("t5_if_pulses", 64'(if_pulses), 64'(1));
    i_read_ready = 1'b0; auto_mem = 1'b1;
    run_drain(20);
    check("t5_single", 64'(if_pulses), 64'(1));

    // Back-to-back IF reads with 1-cycle memory
    clear_obs(); mem_lat = 1;
    if_q.push_back(32'h0); if_q.push_back(32'h4); if_q.push_back(32'h8);
    run_drain(50);
    check("t6_pulses", 64'(if_pulses), 64'(3));
    if (obs_cyc.size() == 3) begin
      check("t6_gap0", 64'(obs_cyc[1] - obs_cyc[0]), 64'(3));
      check("t6_gap1", 64'(obs_cyc[2] - obs_cyc[1]), 64'(3));
      for (int i = 0; i < 3; i++) check($sformatf("t6_addr_%0d", i), 64'(obs_addr[i]), 64'(4 * i));
    end

    // Randomized traffic, stalls and stray ready pulses
    clear_obs(); m_done = 0; rand_mode = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (if_q.size() < 2 && $urandom_range(0, 3) == 0) begin a = $urandom; if_q.push_back(a); end
      if (ls_q.size() < 2 && $urandom_range(0, 3) == 0) begin a = $urandom; ls_q.push_back(a); end
      clk_en = ($urandom_range(0, 7) != 0);
      if (!m_busy) mem_lat = $urandom_range(0, 3);
      cycle();
    end
    clk_en = 1'b1;
    run_drain(200);
    check("rand_completions", 64'(if_pulses + ls_pulses), 64'(m_done));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/read_arbiter.md
# read_arbiter

Two-port read arbiter between the core's instruction-fetch path and load/store unit, multiplexing both onto the core's single RAM read port (`o_read_req` / `o_read_addr` / `i_read_data` / `i_read_ready`). It holds one outstanding read at a time, latches the winning address, and routes the returned data to the owning requester. Writes do not pass through this block; the LSU drives the core's write port directly.

## Interface
Parameters:
- `ADDR_WIDTH`, default 31: MSB index of addresses; buses are `ADDR_WIDTH+1` bits wide.
- `DATA_WIDTH`, default 31: MSB index of data; buses are `DATA_WIDTH+1` bits wide.

Ports:
- `clk`  in  1  single clock.
- `rst`  in  1  reset, synchronous, active-high.
- `clk_en`  in  1  global clock enable; all state updates qualified by it.
- `i_if_req`  in  1  fetch read request (level).
- `i_if_addr`  in  ADDR_WIDTH+1  fetch address.
- `o_if_rvalid`  out  1  fetch data valid (1-cycle pulse).
- `o_if_rdata`  out  DATA_WIDTH+1  fetch data.
- `i_ls_req`  in  1  load read request (level).
- `i_ls_addr`  in  ADDR_WIDTH+1  load address.
- `o_ls_rvalid`  out  1  load data valid (1-cycle pulse).
- `o_ls_rdata`  out  DATA_WIDTH+1  load data.
- `o_read_req`  out  1  RAM read request.
- `o_read_addr`  out  ADDR_WIDTH+1  RAM read address.
- `i_read_data`  in  DATA_WIDTH+1  RAM read data.
- `i_read_ready`  in  1  RAM read complete; data valid this cycle.

## Operation
- States: `IDLE`, `GNT_IF`, `GNT_LS`.
- `IDLE`: if any `req` high, pick a winner, latch its address into `o_read_addr`, go to `GNT_IF` / `GNT_LS`. No request: stay.
- `GNT_x`: `o_read_req`=1, `o_read_addr` stable. On `i_read_ready`=1: `o_x_rvalid`=1 combinationally, `o_x_rdata`=`i_read_data`; next state `IDLE`.
- `o_*_rdata` pass `i_read_data` at all times; only `rvalid` qualifies.
- Requester rules: hold `req` and `addr` until its `rvalid`; may keep `req` high with a new address in the cycle after `rvalid` (back-to-back). Dropping `req` while granted is illegal; the arbiter ignores it and completes the transaction.
- Arbitration when both request in `IDLE`: LS wins (fixed priority) unless round-robin is compiled in.
- `i_read_ready` ignored in `IDLE` (no rvalid, no state change).
- `clk_en`=0: state, latched address, and priority pointer hold; `i_read_ready` ignored; both `rvalid` forced 0.

## Timing
- Reset values: state `IDLE`, `o_read_req`=0, `o_read_addr`=0, `o_if_rvalid`=`o_ls_rvalid`=0, RR pointer = IF-last (LS favoured first).
- Request seen at edge N in `IDLE` -> `o_read_req` high from cycle N+1.
- Response: zero-cycle, same cycle as `i_read_ready`.
- Completion to next grant: `IDLE` for exactly one cycle. Minimum transaction spacing is 2 cycles plus memory latency.
- Reset mid-transaction: next cycle `IDLE`, `o_read_req`=0. A late `i_read_ready` arriving afterwards is ignored.
- `i_read_ready` in the same cycle as `o_read_req` first rises is legal (1-cycle memory).

## Configuration
- `READ_ARB_RR_EN` defined: round-robin. A 1-bit last-grant register updates on each grant, and on a tie the port not granted last wins.
- Undefined: fixed priority, LS over IF. No pointer register.

## Structure
- Shared package `core_pkg`:
  - `arb_state_e` enum (`IDLE`, `GNT_IF`, `GNT_LS`).
  - Port index constants `ARB_PORT_IF`=0 and `ARB_PORT_LS`=1.
- One natural sub-module `read_arb_pick`: combinational winner select from `{req_ls, req_if, last_grant}`. It contains the RR/fixed `ifdef`.

## Test plan
- IF only, `i_if_addr`=0x100, memory ready after 3 cycles with 0xDEADBEEF -> `o_read_addr`=0x100 and `o_if_rvalid` pulses once with that data; `o_ls_rvalid` stays 0.
- IF=0x100 and LS=0x2000 requested in the same cycle, fixed priority -> LS served first, then one `IDLE` cycle, then IF. Each `rvalid` pulses once.
- Same as previous with `READ_ARB_RR_EN`, repeated 4 times with both held -> grants alternate LS, IF, LS, IF.
- Reset asserted during `GNT_LS`, then `i_read_ready`=1 one cycle later -> `o_read_req`=0 and no `rvalid` on either port.
- `clk_en`=0 during `GNT_IF` while `i_read_ready`=1 -> no `rvalid`; `o_read_addr` held. When `clk_en` returns high with `i_read_ready` high -> `o_if_rvalid` pulses once.
- Back-to-back IF reads 0x0, 0x4, 0x8 with 1-cycle memory -> three `rvalid` pulses, spaced 3 cycles apart.
